// File: rtl/aes_pkg.sv
// Shared definitions for the AES block sequencer: block width, chaining-mode
// encodings and the sequencer state encoding.
package aes_pkg;

    localparam int BLK_W = 128;

    localparam logic [2:0] MODE_ECB = 3'b000;
    localparam logic [2:0] MODE_CBC = 3'b001;
    localparam logic [2:0] MODE_CFB = 3'b010;
    localparam logic [2:0] MODE_OFB = 3'b011;
    localparam logic [2:0] MODE_CTR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4
    } state_e;

    // Encodings above MODE_CTR are reserved and rejected at command time.
    function automatic logic mode_is_valid(input logic [2:0] mode);
        return (mode <= MODE_CTR);
    endfunction

endpackage

// File: rtl/aes_chain_state.sv
// Chaining state for the sequencer: the feedback register (CBC/CFB/OFB)
// and the 128-bit counter (CTR). Both are seeded from the command IV.
module aes_chain_state
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_iv,
    input  logic [BLK_W-1:0] iv,
    input  logic             fb_update,
    input  logic             ctr_inc,
    input  logic [2:0]       mode,
    input  logic [BLK_W-1:0] cipher,
    input  logic [BLK_W-1:0] core_out,
    output logic [BLK_W-1:0] fb,
    output logic [BLK_W-1:0] ctr
);

    logic [BLK_W-1:0] fb_q,  fb_d;
    logic [BLK_W-1:0] ctr_q, ctr_d;

    // Next-state selection: IV load wins, otherwise apply the per-block update.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        fb_d  = fb_q;
        ctr_d = ctr_q;
        if (load_iv) begin
            fb_d  = iv;
            ctr_d = iv;
        end else begin
            if (fb_update) begin
                // OFB feeds back the raw keystream; CBC/CFB feed back ciphertext.
                fb_d = (mode == MODE_OFB) ? core_out : cipher;
            end
            if (ctr_inc) begin
                // Natural 128-bit overflow gives the required all-ones -> 0 wrap.
                ctr_d = ctr_q + {{(BLK_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            fb_q  <= '0;
            ctr_q <= '0;
        end else begin
            fb_q  <= fb_d;
            ctr_q <= ctr_d;
        end
    end

    assign fb  = fb_q;
    assign ctr = ctr_q;

endmodule

// File: rtl/aes_block_sequencer.sv
// Multi-block AES encryption sequencer: accepts a command, streams plaintext
// blocks through the shared encrypt core one at a time, applies the selected
// chaining mode and returns ciphertext on a valid/ready stream.
module aes_block_sequencer
    import aes_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [LEN_W-1:0] cmd_nblocks,
    input  logic [BLK_W-1:0] cmd_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             core_start,
    output logic [BLK_W-1:0] core_in,
    input  logic [BLK_W-1:0] core_out,
    input  logic             core_done,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic             busy
);

    state_e           state_q,     state_d;
    logic [2:0]       mode_q,      mode_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [BLK_W-1:0] p_q,         p_d;
    logic [BLK_W-1:0] core_in_q,   core_in_d;
    logic [BLK_W-1:0] out_data_q,  out_data_d;
    logic             cmd_done_q,  cmd_done_d;
    logic             cmd_err_q,   cmd_err_d;

    logic [BLK_W-1:0] fb, ctr, cipher, core_in_sel;
    logic             cmd_hs, in_hs, out_hs, blk_done, last_blk;

    assign cmd_hs   = cmd_valid && (state_q == ST_IDLE);
    assign in_hs    = in_valid  && (state_q == ST_LOAD);
    assign out_hs   = out_ready && (state_q == ST_EMIT);
    assign blk_done = core_done && (state_q == ST_WAIT);
    assign last_blk = (remaining_q == '0);

    // Chaining datapath: core input per mode, and ciphertext from the core result.
    always_comb begin
        cipher      = core_out ^ p_q;
        core_in_sel = ctr;
        case (mode_q)
            MODE_ECB:          core_in_sel = in_data;
            MODE_CBC:          core_in_sel = in_data ^ fb;
            MODE_CFB,
            MODE_OFB:          core_in_sel = fb;
            default:           core_in_sel = ctr;
        endcase
        if (mode_q == MODE_ECB || mode_q == MODE_CBC) begin
            cipher = core_out;
        end
    end

    // Sequencer FSM and per-block register updates.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        p_d         = p_q;
        core_in_d   = core_in_q;
        out_data_d  = out_data_q;
        cmd_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    mode_d      = cmd_mode;
                    remaining_d = cmd_nblocks;
                    if (!mode_is_valid(cmd_mode) || cmd_nblocks == '0) begin
                        cmd_done_d = 1'b1;
                        cmd_err_d  = !mode_is_valid(cmd_mode);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    p_d       = in_data;
                    core_in_d = core_in_sel;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (blk_done) begin
                    out_data_d  = cipher;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_hs) begin
                    state_d = last_blk ? ST_IDLE : ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset also drops any in-flight block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ECB;
            remaining_q <= '0;
            p_q         <= '0;
            core_in_q   <= '0;
            out_data_q  <= '0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            p_q         <= p_d;
            core_in_q   <= core_in_d;
            out_data_q  <= out_data_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    aes_chain_state u_chain (
        .clk       (clk),
        .reset     (reset),
        .load_iv   (cmd_hs),
        .iv        (cmd_iv),
        .fb_update (blk_done && (mode_q == MODE_CBC || mode_q == MODE_CFB ||
                                 mode_q == MODE_OFB)),
        .ctr_inc   (blk_done && (mode_q == MODE_CTR)),
        .mode      (mode_q),
        .cipher    (cipher),
        .core_out  (core_out),
        .fb        (fb),
        .ctr       (ctr)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign in_ready   = (state_q == ST_LOAD);
    assign core_start = (state_q == ST_ISSUE);
    assign out_valid  = (state_q == ST_EMIT);
    assign out_last   = (state_q == ST_EMIT) && last_blk;
    assign busy       = (state_q != ST_IDLE);
    assign core_in    = core_in_q;
    assign out_data   = out_data_q;
    // Degenerate commands end via the registered pulse; real commands end
    // combinationally in the final output handshake cycle.
    assign cmd_done   = cmd_done_q || (out_hs && last_blk);
    assign cmd_err    = cmd_err_q;

endmodule
